// File: rtl/fpga_exit_reporter.sv
// UART exit-value reporter: on a rising exit_valid_i, sends "EXIT:" plus 8 uppercase hex digits, 8N1.
// Define FPGA_EXIT_REPORTER_CRLF_EN to append CR LF to every report.
module fpga_exit_reporter #(
  parameter int CLKS_PER_BIT = 130
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  output logic        tx_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        exit_led_o
);

`ifdef FPGA_EXIT_REPORTER_CRLF_EN
  localparam int N_CHARS = 15;
`else
  localparam int N_CHARS = 13;
`endif

  localparam logic [15:0] BAUD_MAX  = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LAST_CHAR = 4'(N_CHARS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_e;

  state_e      state_q;
  logic        valid_q;
  logic [15:0] baud_q;
  logic [2:0]  bit_q;
  logic [3:0]  char_q;
  logic [31:0] value_q;
  logic        tx_q, busy_q, done_q, led_q;

  logic        rise;
  logic [3:0]  nib;
  logic [7:0]  char_byte;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign rise = exit_valid_i & ~valid_q;

  // Byte currently being shifted out, selected by the character index.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    nib       = 4'h0;
    char_byte = 8'h0A;
    case (char_q)
      4'd0: char_byte = 8'h45;
      4'd1: char_byte = 8'h58;
      4'd2: char_byte = 8'h49;
      4'd3: char_byte = 8'h54;
      4'd4: char_byte = 8'h3A;
      4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12: begin
        nib       = 4'(value_q >> {(4'd12 - char_q), 2'b00});
        char_byte = hex_ascii(nib);
      end
      4'd13:   char_byte = 8'h0D;
      default: char_byte = 8'h0A;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      baud_q  <= '0;
      bit_q   <= '0;
      char_q  <= '0;
      value_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      valid_q <= exit_valid_i;
      case (state_q)
        IDLE, DONE: begin
          tx_q <= 1'b1;
          if (rise) begin
            state_q <= START;
            value_q <= exit_value_i;
            led_q   <= exit_value_i[0];
            baud_q  <= '0;
            bit_q   <= '0;
            char_q  <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        START: begin
          if (baud_q == BAUD_MAX) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= DATA;
            tx_q    <= char_byte[0];
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        DATA: begin
          if (baud_q == BAUD_MAX) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= char_byte[bit_q + 3'd1];
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        STOP: begin
          if (baud_q == BAUD_MAX) begin
            baud_q <= '0;
            if (char_q == LAST_CHAR) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              tx_q    <= 1'b1;
            end else begin
              char_q  <= char_q + 4'd1;
              state_q <= START;
              tx_q    <= 1'b0;
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_o       = tx_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign exit_led_o = led_q;

endmodule

// File: tb/tb_fpga_exit_reporter.sv
// Directed bench for fpga_exit_reporter with CLKS_PER_BIT=4: table of report frames plus reset corner cases.
module tb_fpga_exit_reporter;

`ifdef FPGA_EXIT_REPORTER_CRLF_EN
  localparam int NC = 15;
`else
  localparam int NC = 13;
`endif
  localparam int CPB = 4;

  logic        clk_i;
  logic        rst_i;
  logic        exit_valid_i;
  logic [31:0] exit_value_i;
  logic        tx_o, busy_o, done_o, exit_led_o;

  int checks;
  int failures;

  fpga_exit_reporter #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .exit_valid_i (exit_valid_i),
    .exit_value_i (exit_value_i),
    .tx_o         (tx_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .exit_led_o   (exit_led_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0]    value;
    logic [103:0]   text;
    logic           led;
    int             glitch_at;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_vec(input int idx, input logic [31:0] value, input logic [103:0] text,
                         input logic led, input int glitch_at);
    vecs[idx].value     = value;
    vecs[idx].text      = text;
    vecs[idx].led       = led;
    vecs[idx].glitch_at = glitch_at;
  endtask

  // Raise exit_valid_i with a new value; afterwards we sit in the first start-bit cycle.
  task automatic start_frame(input logic [31:0] value);
    exit_value_i = value;
    exit_valid_i = 1'b1;
    tick();
    check("capture_busy", {31'd0, busy_o}, 32'd1);
    check("capture_done_clr", {31'd0, done_o}, 32'd0);
  endtask

  // Sample every cycle of the frame: exact bit widths, no gaps, decoded bytes, then DONE state.
  task automatic run_frame(input logic [103:0] text, input logic led, input int glitch_at);
    int bad;
    int idle_bad;
    int b;
    logic [7:0] rx;
    logic [7:0] exp_byte;
    logic expbit;
    bad = 0;
    rx  = 8'h00;
    for (int k = 0; k < NC * 10 * CPB; k++) begin
      if (k > 0) tick();
      b = (k % (10 * CPB)) / CPB;
      if (k / (10 * CPB) < 13)       exp_byte = text[8 * (12 - k / (10 * CPB)) +: 8];
      else if (k / (10 * CPB) == 13) exp_byte = 8'h0D;
      else                           exp_byte = 8'h0A;
      if (b == 0)      expbit = 1'b0;
      else if (b == 9) expbit = 1'b1;
      else             expbit = exp_byte[b - 1];
      if (tx_o !== expbit || busy_o !== 1'b1) bad++;
      if (b >= 1 && b <= 8 && (k % CPB) == 2) rx[b - 1] = tx_o;
      if ((k % (10 * CPB)) == 10 * CPB - 1) check("char_byte", {24'd0, rx}, {24'd0, exp_byte});
      if (glitch_at >= 0 && k == glitch_at - 10) exit_valid_i = 1'b0;
      if (glitch_at >= 0 && k == glitch_at) begin
        exit_valid_i = 1'b1;
        exit_value_i = 32'h12345678;
      end
    end
    check("frame_bit_errors", bad, 0);
    tick();
    check("end_busy", {31'd0, busy_o}, 32'd0);
    check("end_done", {31'd0, done_o}, 32'd1);
    check("end_tx", {31'd0, tx_o}, 32'd1);
    check("end_led", {31'd0, exit_led_o}, {31'd0, led});
    if (glitch_at >= 0) begin
      idle_bad = 0;
      for (int i = 0; i < 60; i++) begin
        tick();
        if (busy_o !== 1'b0 || tx_o !== 1'b1 || done_o !== 1'b1) idle_bad++;
      end
      check("no_second_frame", idle_bad, 0);
    end
  endtask

  initial begin
    int idle_bad;
    checks       = 0;
    failures     = 0;
    clk_i        = 1'b0;
    rst_i        = 1'b1;
    exit_valid_i = 1'b0;
    exit_value_i = 32'h0;

    set_vec(0, 32'h00000001, "EXIT:00000001", 1'b1, -1);
    set_vec(1, 32'hDEADBEEF, "EXIT:DEADBEEF", 1'b1, -1);
    set_vec(2, 32'h0000000A, "EXIT:0000000A", 1'b0, -1);
    set_vec(3, 32'hCAFE0042, "EXIT:CAFE0042", 1'b0, 100);

    repeat (3) tick();
    check("rst_tx", {31'd0, tx_o}, 32'd1);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_led", {31'd0, exit_led_o}, 32'd0);
    rst_i = 1'b0;

    idle_bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) idle_bad++;
    end
    check("idle_100", idle_bad, 0);

    for (int v = 0; v < 4; v++) begin
      start_frame(vecs[v].value);
      run_frame(vecs[v].text, vecs[v].led, vecs[v].glitch_at);
      exit_valid_i = 1'b0;
      repeat (3) tick();
      check("done_sticky", {31'd0, done_o}, 32'd1);
    end

    // Reset mid-frame: line must go idle immediately, and stay idle after release.
    start_frame(32'h55AA0000);
    repeat (200) tick();
    #2;
    rst_i = 1'b1;
    #1;
    check("async_rst_tx", {31'd0, tx_o}, 32'd1);
    check("async_rst_busy", {31'd0, busy_o}, 32'd0);
    exit_valid_i = 1'b0;
    tick();
    rst_i = 1'b0;
    idle_bad = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) idle_bad++;
    end
    check("post_rst_idle", idle_bad, 0);

    // exit_valid_i already high at reset release counts as a rising edge.
    rst_i        = 1'b1;
    exit_value_i = 32'h00000007;
    exit_valid_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();
    check("valid_at_release_busy", {31'd0, busy_o}, 32'd1);
    run_frame("EXIT:00000007", 1'b1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
